// File: rtl/tcls_resynch_initiator.sv
// TCLS resynchronisation initiator.
// Drives a register-interface master through the manager's resynch sequence:
// optionally read MISMATCHES_0..2, write the stack pointer to SP_STORE, wait,
// then clear SP_STORE. Optional feature macro: TCLS_INIT_MISMATCH_READ_EN
// (enables the three mismatch-counter reads; without it they are skipped).

package tcls_resynch_initiator_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } tcls_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } tcls_rsp_t;
endpackage

module tcls_resynch_initiator #(
    parameter type         tcls_req_t    = tcls_resynch_initiator_pkg::tcls_req_t,
    parameter type         tcls_rsp_t    = tcls_resynch_initiator_pkg::tcls_rsp_t,
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [31:0] SpStoreOff    = 32'h0,
    parameter logic [31:0] Mm0Off        = 32'h8,
    parameter logic [31:0] Mm1Off        = 32'hC,
    parameter logic [31:0] Mm2Off        = 32'h10,
    parameter int unsigned HoldCycles    = 16,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             resynch_req_i,
    input  logic             fetch_en_i,
    input  logic [31:0]      sp_value_i,
    output tcls_req_t        reg_req_o,
    input  tcls_rsp_t        reg_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0][31:0] mismatch_cnt_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_MM0    = 3'd1;
    localparam logic [2:0] RD_MM1    = 3'd2;
    localparam logic [2:0] RD_MM2    = 3'd3;
    localparam logic [2:0] WR_UNLOAD = 3'd4;
    localparam logic [2:0] HOLD      = 3'd5;
    localparam logic [2:0] WR_RELOAD = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

`ifdef TCLS_INIT_MISMATCH_READ_EN
    localparam logic [2:0] FIRST_STATE = RD_MM0;
`else
    localparam logic [2:0] FIRST_STATE = WR_UNLOAD;
`endif

    localparam logic [31:0] HOLD_LAST    = 32'(HoldCycles - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TimeoutCycles - 1);

    logic [2:0]  state;
    logic [31:0] sp_q;
    logic [31:0] cnt;
    logic        gap_q;
    logic        error_q;
    logic        xfer_state;
    logic        valid;
    logic        xfer_done;
    logic        timeout;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == '1) ? c : c + 32'd1;
    endfunction

    function automatic logic [2:0] next_xfer(input logic [2:0] s);
        case (s)
            RD_MM0:    return RD_MM1;
            RD_MM1:    return RD_MM2;
            RD_MM2:    return WR_UNLOAD;
            WR_UNLOAD: return HOLD;
            default:   return DONE;
        endcase
    endfunction

    assign xfer_state = (state == RD_MM0) || (state == RD_MM1) || (state == RD_MM2) ||
                        (state == WR_UNLOAD) || (state == WR_RELOAD);
    // gap_q forces one idle bus cycle after every completed transfer.
    assign valid      = xfer_state && !gap_q;
    assign xfer_done  = valid && reg_rsp_i.ready;
    assign timeout    = valid && !reg_rsp_i.ready && (cnt == TIMEOUT_LAST);

    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);
    assign error_o = error_q;

    // Request fields are a pure function of state, so they stay stable until ready.
    always_comb begin
        reg_req_o = '0;
        if (valid) begin
            reg_req_o.valid = 1'b1;
            case (state)
                RD_MM0: reg_req_o.addr = BaseAddr + Mm0Off;
                RD_MM1: reg_req_o.addr = BaseAddr + Mm1Off;
                RD_MM2: reg_req_o.addr = BaseAddr + Mm2Off;
                WR_UNLOAD: begin
                    reg_req_o.addr  = BaseAddr + SpStoreOff;
                    reg_req_o.write = 1'b1;
                    reg_req_o.wdata = sp_q;
                    reg_req_o.wstrb = 4'hF;
                end
                WR_RELOAD: begin
                    reg_req_o.addr  = BaseAddr + SpStoreOff;
                    reg_req_o.write = 1'b1;
                    reg_req_o.wstrb = 4'hF;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: fetch_en_i low aborts silently and outranks error/timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            sp_q    <= '0;
            cnt     <= '0;
            gap_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            error_q <= 1'b0;
            gap_q   <= 1'b0;
            if (!fetch_en_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (resynch_req_i) begin
                            if (sp_value_i == 32'd0) begin
                                error_q <= 1'b1;
                            end else begin
                                sp_q  <= sp_value_i;
                                cnt   <= '0;
                                state <= FIRST_STATE;
                            end
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt   <= '0;
                            state <= WR_RELOAD;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    DONE: state <= IDLE;
                    default: begin
                        if (xfer_done) begin
                            cnt <= '0;
                            if (reg_rsp_i.error) begin
                                error_q <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                gap_q <= 1'b1;
                                state <= next_xfer(state);
                            end
                        end else if (timeout) begin
                            cnt     <= '0;
                            error_q <= 1'b1;
                            state   <= IDLE;
                        end else if (valid) begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                endcase
            end
        end
    end

`ifdef TCLS_INIT_MISMATCH_READ_EN
    // Capture MISMATCHES_N on an error-free completed read; hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch_cnt_o <= '0;
        end else if (fetch_en_i && xfer_done && !reg_rsp_i.error) begin
            case (state)
                RD_MM0:  mismatch_cnt_o[0] <= reg_rsp_i.rdata;
                RD_MM1:  mismatch_cnt_o[1] <= reg_rsp_i.rdata;
                RD_MM2:  mismatch_cnt_o[2] <= reg_rsp_i.rdata;
                default: ;
            endcase
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata   = ^reg_rsp_i.rdata;
    assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcls_resynch_initiator.sv
// Bench for tcls_resynch_initiator: directed scenarios plus randomized
// sequences, checked against an expected-transaction model built from the
// sequence rules. Follows TCLS_INIT_MISMATCH_READ_EN like the design does.
`timescale 1ns/1ps
module tb_tcls_resynch_initiator;
    import tcls_resynch_initiator_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SP_A = BASE;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
`ifdef TCLS_INIT_MISMATCH_READ_EN
    localparam bit READS = 1'b1;
`else
    localparam bit READS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             resynch = 1'b0;
    logic             fetch_en = 1'b1;
    logic [31:0]      sp_value = '0;
    tcls_req_t        req;
    tcls_rsp_t        rsp = '0;
    logic             busy_w, done_w, error_w;
    logic [2:0][31:0] mm;

    tcls_resynch_initiator #(
        .BaseAddr(BASE), .SpStoreOff(32'h0), .Mm0Off(32'h8), .Mm1Off(32'hC),
        .Mm2Off(32'h10), .HoldCycles(16), .TimeoutCycles(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .resynch_req_i(resynch), .fetch_en_i(fetch_en),
        .sp_value_i(sp_value), .reg_req_o(req), .reg_rsp_i(rsp), .busy_o(busy_w),
        .done_o(done_w), .error_o(error_w), .mismatch_cnt_o(mm)
    );

    always #5 clk = ~clk;

    // Responder configuration and observed history
    int          rsp_delay = 1;
    logic [31:0] stall_addr = NONE;
    logic [31:0] err_addr = NONE;
    logic [31:0] mem [3];
    tcls_req_t   tx [$];
    int done_n = 0, err_n = 0, stab_viol = 0, gap_viol = 0;
    int last_run = 0, last_gap = 0, cur_run = 0, cur_gap = 0, wait_n = 0;

    // Reference model state
    tcls_req_t   ex [$];
    logic [31:0] exp_mm [3];
    int n_checks = 0, n_fail = 0;

    function automatic logic [31:0] mm_addr(input int i);
        return BASE + 32'h8 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] lookup(input logic [31:0] a);
        for (int i = 0; i < 3; i++) if (a == mm_addr(i)) return mem[i];
        return $urandom;
    endfunction

    // Responder + bus monitor, acting at the falling edge
    initial begin
        tcls_req_t prev_req;
        logic prev_pending, prev_xfer;
        prev_req = '0; prev_pending = 1'b0; prev_xfer = 1'b0;
        forever begin
            @(negedge clk);
            if (req.valid) begin
                if (wait_n >= rsp_delay && req.addr != stall_addr) begin
                    rsp.ready = 1'b1;
                    rsp.error = (req.addr == err_addr);
                    rsp.rdata = lookup(req.addr);
                    tx.push_back(req);
                    wait_n = 0;
                end else begin
                    rsp.ready = 1'b0;
                    rsp.error = 1'b0;
                    rsp.rdata = $urandom;
                    wait_n++;
                end
            end else begin
                rsp = '0;
                wait_n = 0;
            end
            if (prev_pending && req.valid && req != prev_req) stab_viol++;
            if (prev_xfer && req.valid) gap_viol++;
            if (req.valid) begin
                if (cur_run == 0) last_gap = cur_gap;
                cur_run++;
                cur_gap = 0;
            end else begin
                if (cur_run != 0) last_run = cur_run;
                cur_run = 0;
                cur_gap++;
            end
            if (done_w) done_n++;
            if (error_w) err_n++;
            prev_pending = req.valid && !rsp.ready;
            prev_xfer = req.valid && rsp.ready;
            prev_req = req;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input tcls_req_t obs, input tcls_req_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected bus traffic for one sequence: completed reads, unload, reload.
    task automatic model_seq(input logic [31:0] sp, input int n_rd, input bit unl, input bit rel);
        tcls_req_t r;
        ex.delete();
        if (READS) begin
            for (int i = 0; i < n_rd; i++) begin
                r = '0; r.valid = 1'b1; r.addr = mm_addr(i);
                ex.push_back(r);
                exp_mm[i] = mem[i];
            end
        end
        r = '0; r.valid = 1'b1; r.addr = SP_A; r.write = 1'b1; r.wstrb = 4'hF;
        if (unl) begin r.wdata = sp; ex.push_back(r); end
        if (rel) begin r.wdata = 32'h0; ex.push_back(r); end
    endtask

    task automatic clear_log();
        tx.delete();
        done_n = 0;
        err_n = 0;
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_ntx"}, 32'(tx.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < tx.size(); i++)
            check_req($sformatf("%s_tx%0d", tag, i), tx[i], ex[i]);
    endtask

    task automatic check_mm(input string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_mm%0d", tag, i), mm[i], exp_mm[i]);
    endtask

    task automatic start_pulse();
        tick();
        resynch = 1'b1;
        tick();
        resynch = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy_w) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_end"}, 32'(ok), 32'd1);
        repeat (2) tick();
    endtask

    task automatic full_seq(input string tag, input logic [31:0] sp);
        clear_log();
        sp_value = sp;
        model_seq(sp, 3, 1'b1, 1'b1);
        start_pulse();
        check({tag, "_busy"}, 32'(busy_w), 32'd1);
        wait_idle(tag);
        compare_tx(tag);
        check({tag, "_done"}, 32'(done_n), 32'd1);
        check({tag, "_err"}, 32'(err_n), 32'd0);
        check({tag, "_hold"}, 32'(last_gap), 32'd16);
        check_mm(tag);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 3; i++) begin mem[i] = '0; exp_mm[i] = '0; end

        // Reset state, including a request presented while reset is held
        repeat (2) tick();
        resynch = 1'b1;
        tick();
        check_req("rst_req", req, '0);
        check("rst_busy", 32'(busy_w), 32'd0);
        check("rst_done", 32'(done_w), 32'd0);
        check("rst_err", 32'(error_w), 32'd0);
        check_mm("rst");
        resynch = 1'b0;
        rst_ni = 1'b1;
        repeat (2) tick();

        // MISMATCHES 3/0/7, one wait cycle per transfer
        mem[0] = 32'd3; mem[1] = 32'd0; mem[2] = 32'd7;
        rsp_delay = 1;
        full_seq("basic", 32'h1C00_0F00);

        // Randomized sequences
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) mem[i] = $urandom;
            rsp_delay = $urandom_range(0, 3);
            full_seq($sformatf("rnd%0d", k), $urandom | 32'h1);
        end

        // Ready withheld: timeout after 64 valid cycles
        rsp_delay = 0;
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        stall_addr = READS ? mm_addr(1) : SP_A;
        clear_log();
        sp_value = 32'h0BAD_0001;
        model_seq(sp_value, 1, 1'b0, 1'b0);
        start_pulse();
        wait_idle("tmo");
        check("tmo_run", 32'(last_run), 32'd64);
        check("tmo_err", 32'(err_n), 32'd1);
        check("tmo_done", 32'(done_n), 32'd0);
        check("tmo_busy", 32'(busy_w), 32'd0);
        compare_tx("tmo");
        check_mm("tmo");
        stall_addr = NONE;

        // Bus error on the unload write: no reload follows
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        err_addr = SP_A;
        clear_log();
        sp_value = 32'h1234_5678;
        model_seq(sp_value, 3, 1'b1, 1'b0);
        start_pulse();
        wait_idle("berr");
        check("berr_err", 32'(err_n), 32'd1);
        check("berr_done", 32'(done_n), 32'd0);
        compare_tx("berr");
        check_mm("berr");
        err_addr = NONE;

        // fetch_en_i falls during HOLD
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        clear_log();
        sp_value = 32'hCAFE_0010;
        model_seq(sp_value, 3, 1'b1, 1'b0);
        start_pulse();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (tx.size() >= ex.size()) begin ok = 1'b1; break; end
            tick();
        end
        check("fen_unload_seen", 32'(ok), 32'd1);
        repeat (5) tick();
        check("fen_busy_hold", 32'(busy_w), 32'd1);
        fetch_en = 1'b0;
        tick();
        check("fen_busy", 32'(busy_w), 32'd0);
        check("fen_valid", 32'(req.valid), 32'd0);
        fetch_en = 1'b1;
        repeat (30) tick();
        compare_tx("fen");
        check("fen_done", 32'(done_n), 32'd0);
        check("fen_err", 32'(err_n), 32'd0);
        check_mm("fen");

        // Zero stack pointer: error, no bus traffic
        clear_log();
        sp_value = 32'h0;
        model_seq(32'h0, 0, 1'b0, 1'b0);
        start_pulse();
        repeat (3) tick();
        check("spz_err", 32'(err_n), 32'd1);
        check("spz_done", 32'(done_n), 32'd0);
        check("spz_busy", 32'(busy_w), 32'd0);
        compare_tx("spz");

        // Second request while busy is ignored
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        rsp_delay = 1;
        clear_log();
        sp_value = 32'h5A5A_0F0F;
        model_seq(sp_value, 3, 1'b1, 1'b1);
        start_pulse();
        repeat (10) tick();
        check("dbl_busy", 32'(busy_w), 32'd1);
        start_pulse();
        wait_idle("dbl");
        repeat (5) tick();
        check("dbl_done", 32'(done_n), 32'd1);
        check("dbl_idle", 32'(busy_w), 32'd0);
        compare_tx("dbl");
        check_mm("dbl");

        // Asynchronous reset in the middle of a pending transfer
        rsp_delay = 20;
        clear_log();
        start_pulse();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req.valid) begin ok = 1'b1; break; end
            tick();
        end
        check("arst_valid_seen", 32'(ok), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 32'(req.valid), 32'd0);
        check("arst_busy", 32'(busy_w), 32'd0);
        for (int i = 0; i < 3; i++) exp_mm[i] = '0;
        check_mm("arst");
        repeat (2) tick();
        rst_ni = 1'b1;
        rsp_delay = 1;
        tick();

        // Recovery after reset
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        full_seq("post", 32'h0000_1000);

        check("bus_stable", 32'(stab_viol), 32'd0);
        check("bus_gap", 32'(gap_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
